// File: rtl/gray_decode_monitor.sv
// gray_decode_monitor
//   Decode-and-check end of a Gray-coded count path. A qualified Gray sample
//   is captured in stage 1, decoded to binary and classified against the last
//   valid sample in stage 2, and tracked by an IDLE/TRACK/LOCKED monitor plus a
//   saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   enable     sample qualifier for gray_in
//   gray_in    Gray-coded count, WIDTH bits
//   clear_err  synchronous clear of err_count
//   bin_out    registered decoded binary value
//   bin_valid  one-cycle pulse, bin_out carries a new sample
//   step_ok    with bin_valid: sample is previous + 1 (mod 2^WIDTH)
//   step_err   with bin_valid: sample is neither previous nor previous + 1
//   locked     registered decode of the LOCKED state
//   err_count  saturating count of step_err pulses; it counts the step_err
//              output, so it moves on the edge after the pulse is visible
//              and clear_err in that same cycle leaves it at 1
module gray_decode_monitor #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_ok,
    output logic             step_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned RunW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [RunW-1:0] RunLast = RunW'(LOCK_COUNT - 1);
    localparam logic [ERR_W-1:0] ErrMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StLocked
    } state_e;

    // Stage 1
    logic [WIDTH-1:0] g1_q, g1_d;
    logic             v1_q, v1_d;

    // Stage 2 / outputs
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    // Monitor state
    logic [WIDTH-1:0] ref_q, ref_d;
    state_e           state_q, state_d;
    logic [RunW-1:0]  run_q, run_d;

    // Combinational decode and classification
    logic [WIDTH-1:0] bin_dec;
    logic [WIDTH-1:0] delta;
    logic             class_ok;
    logic             class_err;

    // Stage 1: an idle cycle keeps the captured sample; only the valid bit drops.
    always_comb begin
        v1_d = enable;
        g1_d = enable ? gray_in : g1_q;
    end

    // MSB passes through; each lower bit is the XOR of all Gray bits above and at it.
    always_comb begin
        bin_dec = '0;
        bin_dec[WIDTH-1] = g1_q[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin_dec[i] = bin_dec[i+1] ^ g1_q[i];
        end
    end

    // Modular difference handles the 2^WIDTH-1 -> 0 wrap as a +1 step.
    always_comb begin
        delta     = bin_dec - ref_q;
        class_ok  = 1'b0;
        class_err = 1'b0;
        if (v1_q && (state_q != StIdle)) begin
            class_ok  = (delta == WIDTH'(1));
            class_err = (delta != WIDTH'(1)) && (delta != '0);
        end
    end

    // Monitor FSM, advanced only on edges that register a valid sample.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (v1_q) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StTrack;
                    run_d   = '0;
                end
                StTrack: begin
                    if (class_ok) begin
                        if (run_q == RunLast) begin
                            state_d = StLocked;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RunW'(1);
                        end
                    end else if (class_err) begin
                        run_d = '0;
                    end
                end
                StLocked: begin
                    if (class_err) begin
                        state_d = StTrack;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Stage 2 registers and the reference follow every valid sample, errors included.
    always_comb begin
        bin_d    = v1_q ? bin_dec : bin_q;
        ref_d    = v1_q ? bin_dec : ref_q;
        valid_d  = v1_q;
        ok_d     = class_ok;
        err_d    = class_err;
        locked_d = (state_q == StLocked);
    end

    // Error counter counts registered step_err pulses; a clear coinciding with
    // a pulse keeps that one error.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_err) begin
            cnt_d = err_q ? ERR_W'(1) : '0;
        end else if (err_q && (cnt_q != ErrMax)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            g1_q     <= '0;
            v1_q     <= 1'b0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            ref_q    <= '0;
            state_q  <= StIdle;
            run_q    <= '0;
        end else begin
            g1_q     <= g1_d;
            v1_q     <= v1_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            state_q  <= state_d;
            run_q    <= run_d;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign step_ok   = ok_q;
    assign step_err  = err_q;
    assign locked    = locked_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Bench for gray_decode_monitor (WIDTH=8, LOCK_COUNT=4, ERR_W=2).
module tb_gray_decode_monitor;

    localparam int W    = 8;
    localparam int LOCK = 4;
    localparam int EW   = 2;
    localparam int EMAX = (1 << EW) - 1;
    localparam int MOD  = 1 << W;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] gray_in;
    logic         clear_err;
    logic [W-1:0] bin_out;
    logic         bin_valid;
    logic         step_ok;
    logic         step_err;
    logic         locked;
    logic [EW-1:0] err_count;

    gray_decode_monitor #(
        .WIDTH      (W),
        .LOCK_COUNT (LOCK),
        .ERR_W      (EW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .gray_in   (gray_in),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_ok   (step_ok),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 track, 2 locked
    int m_ready = 0;
    int m_pv = 0, m_pg = 0;
    int m_mode = 0, m_run = 0, m_ref = 0;
    int e_bin = 0, e_val = 0, e_ok = 0, e_err = 0, e_lock = 0, e_cnt = 0;

    function automatic int gray2bin(input int g);
        int b = 0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b & (MOD - 1);
    endfunction

    function automatic int bin2gray(input int b);
        return (b ^ (b >> 1)) & (MOD - 1);
    endfunction

    task automatic model_step(input logic rst, input logic en, input int g, input logic clr);
        int b, d, nok, nerr;
        if (!rst) begin
            m_pv = 0; m_pg = 0; m_mode = 0; m_run = 0; m_ref = 0;
            e_bin = 0; e_val = 0; e_ok = 0; e_err = 0; e_lock = 0; e_cnt = 0;
            m_ready = 1;
        end else begin
            // counter reacts to the step_err pulse currently on the outputs
            if (clr) e_cnt = e_err ? 1 : 0;
            else if (e_err != 0 && e_cnt < EMAX) e_cnt++;
            e_lock = (m_mode == 2) ? 1 : 0;
            nok = 0; nerr = 0;
            if (m_pv != 0) begin
                b = gray2bin(m_pg);
                d = (b - m_ref + MOD) % MOD;
                if (m_mode != 0) begin
                    nok  = (d == 1) ? 1 : 0;
                    nerr = (d != 1 && d != 0) ? 1 : 0;
                end
                if (m_mode == 0) begin
                    m_mode = 1; m_run = 0;
                end else if (m_mode == 1) begin
                    if (nok != 0) begin
                        m_run++;
                        if (m_run == LOCK) begin m_mode = 2; m_run = 0; end
                    end else if (nerr != 0) m_run = 0;
                end else if (nerr != 0) begin
                    m_mode = 1; m_run = 0;
                end
                m_ref = b;
                e_bin = b;
            end
            e_val = m_pv; e_ok = nok; e_err = nerr;
            m_pv = en ? 1 : 0;
            if (en) m_pg = g;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(reset_n, enable, int'(gray_in), clear_err);
        end
    end

    // ---------------- compare process ----------------
    int qb[$];
    int qo[$];
    int qe[$];

    initial begin
        forever begin
            @(negedge clk);
            if (m_ready != 0) begin
                chk("bin_valid", 32'(bin_valid), e_val);
                if (e_val != 0) chk("bin_out", 32'(bin_out), e_bin);
                chk("step_ok", 32'(step_ok), e_ok);
                chk("step_err", 32'(step_err), e_err);
                chk("locked", 32'(locked), e_lock);
                chk("err_count", 32'(err_count), e_cnt);
                if (bin_valid === 1'b1) begin
                    qb.push_back(int'(bin_out));
                    qo.push_back(int'(step_ok));
                    qe.push_back(int'(step_err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rst, input logic en, input int g, input logic clr);
        reset_n   = rst;
        enable    = en;
        gray_in   = W'(g);
        clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic clear_q();
        qb.delete(); qo.delete(); qe.delete();
    endtask

    initial begin
        int cur;
        reset_n = 1'b0; enable = 1'b0; gray_in = '0; clear_err = 1'b0;

        // Count sequence
        drive(1'b0, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b0);
        chk("reset_locked", 32'(locked), 0);
        chk("reset_err_count", 32'(err_count), 0);
        clear_q();
        drive(1'b1, 1'b1, 'h00, 1'b0);
        drive(1'b1, 1'b1, 'h01, 1'b0);
        drive(1'b1, 1'b1, 'h03, 1'b0);
        drive(1'b1, 1'b1, 'h02, 1'b0);
        drive(1'b1, 1'b1, 'h06, 1'b0);
        drive(1'b1, 1'b1, 'h07, 1'b0);
        idle(3);
        chk("count_pulses", qb.size(), 6);
        if (qb.size() == 6) begin
            chk("count_bin0", qb[0], 0); chk("count_ok0", qo[0], 0);
            chk("count_bin2", qb[2], 2); chk("count_ok2", qo[2], 1);
            chk("count_bin4", qb[4], 4); chk("count_ok4", qo[4], 1);
            chk("count_bin5", qb[5], 5); chk("count_ok5", qo[5], 1);
        end
        chk("count_locked", 32'(locked), 1);
        chk("count_err", 32'(err_count), 0);

        // Wrap while locked
        drive(1'b0, 1'b0, 0, 1'b0);
        clear_q();
        for (int b = 250; b < 256; b++) drive(1'b1, 1'b1, bin2gray(b), 1'b0);
        drive(1'b1, 1'b1, 'h00, 1'b0);
        idle(3);
        chk("wrap_pulses", qb.size(), 7);
        if (qb.size() == 7) begin
            chk("wrap_bin255", qb[5], 255); chk("wrap_ok255", qo[5], 1);
            chk("wrap_bin0", qb[6], 0);     chk("wrap_ok0", qo[6], 1);
        end
        chk("wrap_locked", 32'(locked), 1);

        // Jump while locked
        clear_q();
        drive(1'b1, 1'b1, 'h01, 1'b0);
        drive(1'b1, 1'b1, 'h03, 1'b0);
        drive(1'b1, 1'b1, 'h02, 1'b0);
        drive(1'b1, 1'b1, 'h07, 1'b0);
        drive(1'b1, 1'b1, 'h05, 1'b0);
        idle(3);
        chk("jump_pulses", qb.size(), 5);
        if (qb.size() == 5) begin
            chk("jump_bin5", qb[3], 5); chk("jump_err5", qe[3], 1);
            chk("jump_bin6", qb[4], 6); chk("jump_ok6", qo[4], 1);
        end
        chk("jump_locked", 32'(locked), 0);
        chk("jump_err", 32'(err_count), 1);

        // Hold and gaps
        drive(1'b0, 1'b0, 0, 1'b0);
        clear_q();
        drive(1'b1, 1'b1, 'h00, 1'b0);
        drive(1'b1, 1'b1, 'h01, 1'b0);
        drive(1'b1, 1'b1, 'h03, 1'b0);
        drive(1'b1, 1'b1, 'h02, 1'b0);
        drive(1'b1, 1'b1, 'h06, 1'b0);
        drive(1'b1, 1'b1, 'h06, 1'b0);
        drive(1'b1, 1'b0, 'h06, 1'b0);
        drive(1'b1, 1'b1, 'h06, 1'b0);
        drive(1'b1, 1'b0, 'h06, 1'b0);
        drive(1'b1, 1'b1, 'h06, 1'b0);
        idle(3);
        chk("hold_pulses", qb.size(), 8);
        for (int i = 5; i < 8 && i < qb.size(); i++) begin
            chk("hold_bin", qb[i], 4);
            chk("hold_flags", qo[i] + qe[i], 0);
        end
        chk("hold_locked", 32'(locked), 1);

        // Saturation and clear
        clear_q();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, (i % 2 == 0) ? 'h00 : 'h0F, 1'b0);
        idle(3);
        chk("sat_err_pulses", qe.sum(), 6);
        chk("sat_err", 32'(err_count), 3);
        drive(1'b1, 1'b1, 'h00, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b1);
        idle(1);
        chk("clear_with_err", 32'(err_count), 1);
        drive(1'b1, 1'b0, 0, 1'b1);
        idle(1);
        chk("clear_alone", 32'(err_count), 0);

        // Reset mid-operation
        clear_q();
        drive(1'b1, 1'b1, 'h06, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b0);
        idle(3);
        chk("rst_no_pulse", qb.size(), 0);
        chk("rst_bin_out", 32'(bin_out), 0);
        chk("rst_locked", 32'(locked), 0);
        drive(1'b1, 1'b1, 'h13, 1'b0);
        idle(3);
        chk("rst_first_pulse", qb.size(), 1);
        if (qb.size() == 1) begin
            chk("rst_first_bin", qb[0], 29);
            chk("rst_first_flags", qo[0] + qe[0], 0);
        end

        // Randomized traffic
        cur = $urandom_range(0, MOD - 1);
        for (int n = 0; n < 3000; n++) begin
            int p;
            logic en, rst, clr;
            rst = ($urandom_range(0, 199) != 0);
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 29) == 0);
            if (en) begin
                p = $urandom_range(0, 99);
                if (p < 75) cur = (cur + 1) % MOD;
                else if (p >= 87) cur = $urandom_range(0, MOD - 1);
            end
            drive(rst, en, bin2gray(cur), clr);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
